inst_assembler: RTL and testbench

Loader-side counterpart to the core's instruction field decoder: accepts decoded RISC-V fields plus an immediate over a valid/ready handshake and re-encodes them into 32-bit instruction words. It writes the words to sequential instruction-memory addresses. It sits between a test or boot source that produces field-level instructions and the IMEM write port, and tracks fill level and encoding errors.

---
 rtl/inst_assembler_pkg.sv | 26 ++
 rtl/inst_field_encoder.sv | 32 +++
 rtl/inst_assembler.sv | 100 ++++++++++
 tb/tb_inst_assembler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/inst_assembler_pkg.sv
// Shared RISC-V type codes, opcodes and assembler FSM encodings.
// Type codes and opcodes match the core's field decoder.
package inst_assembler_pkg;

  localparam logic [2:0] R_TYPE = 3'd0;
  localparam logic [2:0] I_TYPE = 3'd1;
  localparam logic [2:0] S_TYPE = 3'd2;
  localparam logic [2:0] B_TYPE = 3'd3;
  localparam logic [2:0] U_TYPE = 3'd4;
  localparam logic [2:0] J_TYPE = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/inst_field_encoder.sv
// Combinational re-encoder: decoded fields + byte-offset immediate -> RV32 word.
// Types 6/7 raise illegal and produce a zero word.
module inst_field_encoder
  import inst_assembler_pkg::*;
(
  input  logic [2:0]  inst_type,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = 32'd0;
    illegal = 1'b0;
    case (inst_type)
      R_TYPE:  word = {funct7, rs2, rs1, funct3, rd, opcode};
      I_TYPE:  word = {imm[11:0], rs1, funct3, rd, opcode};
      S_TYPE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      B_TYPE:  word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      U_TYPE:  word = {imm[31:12], rd, opcode};
      J_TYPE:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_assembler.sv
// Field-bundle to IMEM writer: encodes one instruction per accept and writes it
// to the next sequential word address, tracking fill level and a sticky error.
module inst_assembler
  import inst_assembler_pkg::*;
#(
  parameter int W_SIZE = 32,
  parameter int AWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        inst_type,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [AWIDTH-1:0] imem_addr,
  output logic [W_SIZE-1:0] imem_din,
  output logic [AWIDTH:0]   count,
  output logic              full,
  output logic              err
);

  logic [1:0]        r_state;
  logic [AWIDTH-1:0] r_ptr;
  logic [AWIDTH:0]   r_count;
  logic [W_SIZE-1:0] r_din;
  logic              r_err;

  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_last;

  inst_field_encoder u_enc (
    .inst_type (inst_type),
    .opcode    (opcode),
    .rd        (rd),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct7    (funct7),
    .imm       (imm),
    .word      (w_word),
    .illegal   (w_illegal)
  );

  // Count about to reach capacity on this write.
  assign w_last = (r_count == {1'b0, {AWIDTH{1'b1}}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_din   <= '0;
      r_err   <= 1'b0;
    end else if (clear) begin
      // A coinciding WRITE still strobes this cycle; only the bookkeeping restarts.
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_din   <= W_SIZE'(w_word);
              r_state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          r_ptr   <= r_ptr + 1'b1;
          r_count <= r_count + 1'b1;
          r_state <= w_last ? ST_FULL : ST_IDLE;
        end
        ST_FULL: r_state <= ST_FULL;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign imem_we   = (r_state == ST_WRITE);
  assign full      = (r_state == ST_FULL);
  assign imem_addr = r_ptr;
  assign imem_din  = r_din;
  assign count     = r_count;
  assign err       = r_err;

endmodule

// File: tb/tb_inst_assembler.sv
// Directed bench: a full-size instance for encoding/throughput/error/reset checks
// and an AWIDTH=2 instance for fill, wrap and clear behaviour.
module tb_inst_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, clr_a, clr_b, va, vb;
  logic [2:0]  f_type;
  logic [6:0]  f_op, f_f7;
  logic [4:0]  f_rd, f_rs1, f_rs2;
  logic [2:0]  f_f3;
  logic [31:0] f_imm;

  logic        rdy_a, we_a, full_a, err_a;
  logic [13:0] addr_a;
  logic [31:0] din_a;
  logic [14:0] cnt_a;

  logic        rdy_b, we_b, full_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] din_b;
  logic [2:0]  cnt_b;

  int n_vec = 0;
  int n_miss = 0;

  inst_assembler #(.W_SIZE(32), .AWIDTH(14)) u_a (
    .clk(clk), .rst(rst_a), .clear(clr_a), .in_valid(va), .in_ready(rdy_a),
    .inst_type(f_type), .opcode(f_op), .rd(f_rd), .funct3(f_f3), .rs1(f_rs1),
    .rs2(f_rs2), .funct7(f_f7), .imm(f_imm), .imem_we(we_a), .imem_addr(addr_a),
    .imem_din(din_a), .count(cnt_a), .full(full_a), .err(err_a)
  );

  inst_assembler #(.W_SIZE(32), .AWIDTH(2)) u_b (
    .clk(clk), .rst(rst_b), .clear(clr_b), .in_valid(vb), .in_ready(rdy_b),
    .inst_type(f_type), .opcode(f_op), .rd(f_rd), .funct3(f_f3), .rs1(f_rs1),
    .rs2(f_rs2), .funct7(f_f7), .imm(f_imm), .imem_we(we_b), .imem_addr(addr_b),
    .imem_din(din_b), .count(cnt_b), .full(full_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_f(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [6:0] f7, input logic [31:0] im);
    f_type = t; f_op = op; f_rd = rd; f_f3 = f3;
    f_rs1 = rs1; f_rs2 = rs2; f_f7 = f7; f_imm = im;
  endtask

  // One accept on the full-size instance, checking the write cycle that follows.
  task automatic send_a(input string tag, input logic [31:0] exp_din, input logic [31:0] exp_addr);
    @(negedge clk); va = 1'b1;
    @(posedge clk); #1; va = 1'b0;
    chk({tag, "_we"},   32'(we_a), 32'd1);
    chk({tag, "_rdy"},  32'(rdy_a), 32'd0);
    chk({tag, "_addr"}, 32'(addr_a), exp_addr);
    chk({tag, "_din"},  din_a, exp_din);
    @(posedge clk); #1;
    chk({tag, "_we_off"}, 32'(we_a), 32'd0);
  endtask

  task automatic send_b(input string tag, input logic [31:0] exp_addr);
    @(negedge clk); vb = 1'b1;
    @(posedge clk); #1; vb = 1'b0;
    chk({tag, "_we"},   32'(we_b), 32'd1);
    chk({tag, "_addr"}, 32'(addr_b), exp_addr);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0; va = 1'b0; vb = 1'b0;
    set_f(3'd0, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'h0);
    #3;
    chk("rst_rdy",  32'(rdy_a), 32'd1);
    chk("rst_we",   32'(we_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_din",  din_a, 32'd0);
    chk("rst_cnt",  32'(cnt_a), 32'd0);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_err",  32'(err_a), 32'd0);
    @(negedge clk); rst_a = 1'b0; rst_b = 1'b0;

    // Encoding of each instruction format.
    set_f(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5);
    send_a("enc_i", 32'h00500093, 32'd0);
    set_f(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'd0);
    send_a("enc_r", 32'h002081B3, 32'd1);
    set_f(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'd8);
    send_a("enc_s", 32'h0020A423, 32'd2);
    set_f(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00, 32'hFFFFFFFC);
    send_a("enc_b", 32'hFE208EE3, 32'd3);
    set_f(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd8);
    send_a("enc_j", 32'h008000EF, 32'd4);
    set_f(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000);
    send_a("enc_u", 32'h123452B7, 32'd5);
    chk("cnt_after6", 32'(cnt_a), 32'd6);

    // Valid held high: one write every second cycle.
    set_f(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5);
    @(negedge clk); va = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_we%0d", i), 32'(we_a), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i == 0) chk("hold_addr0", 32'(addr_a), 32'd6);
      if (i == 2) chk("hold_addr2", 32'(addr_a), 32'd7);
    end
    va = 1'b0;
    @(posedge clk); #1;
    chk("hold_cnt", 32'(cnt_a), 32'd8);

    // Illegal type: sticky error, no write, same address reused.
    set_f(3'd6, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5);
    @(negedge clk); va = 1'b1;
    @(posedge clk); #1; va = 1'b0;
    chk("ill_err", 32'(err_a), 32'd1);
    chk("ill_we",  32'(we_a), 32'd0);
    chk("ill_cnt", 32'(cnt_a), 32'd8);
    @(posedge clk); #1;
    chk("ill_err_hold", 32'(err_a), 32'd1);
    set_f(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5);
    send_a("ill_next", 32'h00500093, 32'd8);
    chk("ill_next_cnt", 32'(cnt_a), 32'd9);

    // Asynchronous reset in the middle of a write cycle.
    @(negedge clk); va = 1'b1;
    @(posedge clk); #1; va = 1'b0;
    chk("arst_pre_we", 32'(we_a), 32'd1);
    #2; rst_a = 1'b1; #1;
    chk("arst_we",   32'(we_a), 32'd0);
    chk("arst_rdy",  32'(rdy_a), 32'd1);
    chk("arst_addr", 32'(addr_a), 32'd0);
    chk("arst_din",  din_a, 32'd0);
    chk("arst_cnt",  32'(cnt_a), 32'd0);
    chk("arst_err",  32'(err_a), 32'd0);
    chk("arst_full", 32'(full_a), 32'd0);
    @(negedge clk); rst_a = 1'b0;

    // Small instance: fill, hold, clear, refill.
    set_f(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'd0);
    for (int i = 0; i < 4; i++) send_b($sformatf("fill%0d", i), 32'(i));
    chk("fill_full", 32'(full_b), 32'd1);
    chk("fill_cnt",  32'(cnt_b), 32'd4);
    chk("fill_rdy",  32'(rdy_b), 32'd0);
    chk("fill_wrap", 32'(addr_b), 32'd0);
    @(negedge clk); vb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("held_we%0d", i), 32'(we_b), 32'd0);
    end
    clr_b = 1'b1;
    @(posedge clk); #1;
    chk("clr_cnt",  32'(cnt_b), 32'd0);
    chk("clr_rdy",  32'(rdy_b), 32'd1);
    chk("clr_we",   32'(we_b), 32'd0);
    chk("clr_full", 32'(full_b), 32'd0);
    clr_b = 1'b0;
    @(posedge clk); #1; vb = 1'b0;
    chk("fifth_we",   32'(we_b), 32'd1);
    chk("fifth_addr", 32'(addr_b), 32'd0);
    chk("fifth_din",  din_b, 32'h002081B3);
    @(posedge clk); #1;
    chk("fifth_cnt", 32'(cnt_b), 32'd1);
    send_b("pre1", 32'd1);
    send_b("pre2", 32'd2);

    // Clear coinciding with the write at address 3.
    @(negedge clk); vb = 1'b1;
    @(posedge clk); #1; vb = 1'b0;
    clr_b = 1'b1;
    chk("cw_we",   32'(we_b), 32'd1);
    chk("cw_addr", 32'(addr_b), 32'd3);
    @(posedge clk); #1; clr_b = 1'b0;
    chk("cw_post_addr", 32'(addr_b), 32'd0);
    chk("cw_post_cnt",  32'(cnt_b), 32'd0);
    chk("cw_post_we",   32'(we_b), 32'd0);
    chk("cw_post_full", 32'(full_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
